// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 256x64 data memory between the
// pipeline memory stage (P) and the loader/debug port (L).
// One grant per cycle. P wins ties unless L has waited MAX_WAIT P grants.
// Read data returns one cycle after the grant. Out-of-range accesses are
// answered with an error pulse instead of touching the memory.
module dmem_arbiter #(
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // pipeline port
   input  logic              p_req,
   input  logic              p_we,
   input  logic [63:0]       p_addr,
   input  logic [63:0]       p_wdata,
   output logic              p_gnt,
   output logic              p_stall,
   output logic              p_rvalid,
   output logic [63:0]       p_rdata,
   output logic              p_err,
   // loader port
   input  logic              l_req,
   input  logic              l_we,
   input  logic [63:0]       l_addr,
   input  logic [63:0]       l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [63:0]       l_rdata,
   output logic              l_err,
   // memory
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_rdata
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {OWN_P = 1'b0, OWN_L = 1'b1} owner_t;

   logic [CNT_W-1:0] starve_cnt;
   owner_t           rd_owner;   // owner of the last grant, steers the response
   logic             rd_pend;
   logic             rd_err;

   logic             p_win, l_win, granted, sel_we, err;
   logic [63:0]      sel_addr, sel_wdata;

   // Grant, request mux, range check and memory drive. Grants are masked
   // while reset is asserted so nothing reaches the memory during reset.
   always_comb begin
      p_win     = p_req & (~l_req | (starve_cnt != CNT_W'(MAX_WAIT)));
      l_win     = l_req & ~p_win;
      p_gnt     = p_win & rst_n;
      l_gnt     = l_win & rst_n;
      granted   = p_gnt | l_gnt;
      sel_we    = l_gnt ? l_we    : p_we;
      sel_addr  = l_gnt ? l_addr  : p_addr;
      sel_wdata = l_gnt ? l_wdata : p_wdata;
      err       = granted & (sel_addr >= 64'(DEPTH));
      mem_en    = granted & ~err;
      mem_we    = mem_en & sel_we;
      mem_addr  = mem_en ? sel_addr[ADDR_W-1:0] : '0;
      mem_wdata = mem_en ? sel_wdata : '0;
      p_stall   = p_req & ~p_gnt;
   end

   // Starvation counter: counts P grants taken while L waits, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (l_gnt || !l_req)
         starve_cnt <= '0;
      else if (p_gnt && starve_cnt != CNT_W'(MAX_WAIT))
         starve_cnt <= starve_cnt + 1'b1;
   end

   // Response pipe: remember reads and errored accesses for one cycle.
   // Reset clears rd_pend, so an in-flight read never produces rvalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend  <= 1'b0;
         rd_owner <= OWN_P;
         rd_err   <= 1'b0;
      end else begin
         rd_pend  <= granted & (~sel_we | err);
         rd_err   <= err;
         if (granted)
            rd_owner <= l_gnt ? OWN_L : OWN_P;
      end
   end

   // Route the returning response to its owner; the other port sees zeros.
   always_comb begin
      p_rvalid = rd_pend & (rd_owner == OWN_P);
      l_rvalid = rd_pend & (rd_owner == OWN_L);
      p_err    = p_rvalid & rd_err;
      l_err    = l_rvalid & rd_err;
      p_rdata  = (p_rvalid & ~rd_err) ? mem_rdata : '0;
      l_rdata  = (l_rvalid & ~rd_err) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x64 memory.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p_req, p_we, l_req, l_we;
   logic [63:0] p_addr, p_wdata, l_addr, l_wdata;
   logic        p_gnt, p_stall, p_rvalid, p_err;
   logic [63:0] p_rdata;
   logic        l_gnt, l_rvalid, l_err;
   logic [63:0] l_rdata;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata = '0;
   logic [63:0] mem [256] = '{default: 64'h0};

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DEPTH(256), .ADDR_W(8), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata), .p_err(p_err),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Memory model: writes land at the edge, reads return the next cycle.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      logic        p_req, p_we;
      logic [63:0] p_addr, p_wdata;
      logic        l_req, l_we;
      logic [63:0] l_addr, l_wdata;
      logic        e_pg, e_lg, e_en, e_we;
      logic        e_pv, e_pe;
      logic [63:0] e_pd;
      logic        e_lv, e_le;
      logic [63:0] e_ld;
   } vec_t;

   vec_t vt [19];

   function automatic vec_t mk(
      input logic pr, input logic pw, input logic [63:0] pa, input logic [63:0] pd,
      input logic lr, input logic lw, input logic [63:0] la, input logic [63:0] ld,
      input logic pg, input logic lg, input logic en, input logic we,
      input logic pv, input logic pe, input logic [63:0] prd,
      input logic lv, input logic le, input logic [63:0] lrd);
      vec_t v;
      v.p_req = pr; v.p_we = pw; v.p_addr = pa; v.p_wdata = pd;
      v.l_req = lr; v.l_we = lw; v.l_addr = la; v.l_wdata = ld;
      v.e_pg = pg; v.e_lg = lg; v.e_en = en; v.e_we = we;
      v.e_pv = pv; v.e_pe = pe; v.e_pd = prd;
      v.e_lv = lv; v.e_le = le; v.e_ld = lrd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
      l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
   endtask

   task automatic chk_resp(input string tag,
                           input logic pv, input logic pe, input logic [63:0] pd,
                           input logic lv, input logic le, input logic [63:0] ld);
      chk({tag, " p_rvalid"}, 64'(p_rvalid), 64'(pv));
      chk({tag, " p_err"},    64'(p_err),    64'(pe));
      chk({tag, " p_rdata"},  p_rdata,       pd);
      chk({tag, " l_rvalid"}, 64'(l_rvalid), 64'(lv));
      chk({tag, " l_err"},    64'(l_err),    64'(le));
      chk({tag, " l_rdata"},  l_rdata,       ld);
   endtask

   initial begin
      // Columns: P req/we/addr/wdata | L req/we/addr/wdata |
      //          expect p_gnt l_gnt mem_en mem_we | P resp v/err/data | L resp v/err/data
      vt[0]  = mk(0,0,64'h0,0,             0,0,64'h0,0,            0,0,0,0, 0,0,0,           0,0,0);
      vt[1]  = mk(1,1,64'h10,64'hDEAD,     0,0,64'h0,0,            1,0,1,1, 0,0,0,           0,0,0);
      vt[2]  = mk(1,0,64'h10,0,            0,0,64'h0,0,            1,0,1,0, 0,0,0,           0,0,0);
      vt[3]  = mk(0,0,64'h0,0,             0,0,64'h0,0,            0,0,0,0, 1,0,64'hDEAD,    0,0,0);
      vt[4]  = mk(1,1,64'h05,64'h1234,     0,0,64'h0,0,            1,0,1,1, 0,0,0,           0,0,0);
      vt[5]  = mk(1,0,64'h05,0,            0,0,64'h0,0,            1,0,1,0, 0,0,0,           0,0,0);
      vt[6]  = mk(0,0,64'h0,0,             1,1,64'h20,64'hAAAA5555,0,1,1,1, 1,0,64'h1234,    0,0,0);
      vt[7]  = mk(1,1,64'h21,64'hBEEF,     0,0,64'h0,0,            1,0,1,1, 0,0,0,           0,0,0);
      vt[8]  = mk(0,0,64'h0,0,             1,0,64'h20,0,           0,1,1,0, 0,0,0,           0,0,0);
      vt[9]  = mk(1,0,64'h21,0,            0,0,64'h0,0,            1,0,1,0, 0,0,0,           1,0,64'hAAAA5555);
      vt[10] = mk(0,0,64'h0,0,             0,0,64'h0,0,            0,0,0,0, 1,0,64'hBEEF,    0,0,0);
      vt[11] = mk(1,0,64'h100,0,           0,0,64'h0,0,            1,0,0,0, 0,0,0,           0,0,0);
      vt[12] = mk(1,1,64'h1_0000_0000,64'hFFFF, 0,0,64'h0,0,       1,0,0,0, 1,1,0,           0,0,0);
      vt[13] = mk(0,0,64'h0,0,             1,0,64'h10,0,           0,1,1,0, 1,1,0,           0,0,0);
      vt[14] = mk(1,0,64'h00,0,            0,0,64'h0,0,            1,0,1,0, 0,0,0,           1,0,64'hDEAD);
      vt[15] = mk(0,0,64'h0,0,             1,0,64'h300,0,          0,1,0,0, 1,0,64'h0,       0,0,0);
      vt[16] = mk(0,0,64'h0,0,             0,0,64'h0,0,            0,0,0,0, 0,0,0,           1,1,0);
      vt[17] = mk(1,0,64'h10,0,            1,0,64'h20,0,           1,0,1,0, 0,0,0,           0,0,0);
      vt[18] = mk(0,0,64'h0,0,             0,0,64'h0,0,            0,0,0,0, 1,0,64'hDEAD,    0,0,0);

      idle_inputs();
      rst_n = 0;
      #1;
      chk("reset p_gnt",  64'(p_gnt),  64'h0);
      chk("reset mem_en", 64'(mem_en), 64'h0);
      chk("reset mem_addr", 64'(mem_addr), 64'h0);
      chk_resp("reset", 0,0,0, 0,0,0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;

      // Table-driven single-cycle vectors
      foreach (vt[i]) begin
         string t;
         @(negedge clk);
         t = $sformatf("vec%0d", i);
         p_req = vt[i].p_req; p_we = vt[i].p_we; p_addr = vt[i].p_addr; p_wdata = vt[i].p_wdata;
         l_req = vt[i].l_req; l_we = vt[i].l_we; l_addr = vt[i].l_addr; l_wdata = vt[i].l_wdata;
         #1;
         chk({t, " p_gnt"},   64'(p_gnt),   64'(vt[i].e_pg));
         chk({t, " l_gnt"},   64'(l_gnt),   64'(vt[i].e_lg));
         chk({t, " p_stall"}, 64'(p_stall), 64'(vt[i].p_req & ~vt[i].e_pg));
         chk({t, " mem_en"},  64'(mem_en),  64'(vt[i].e_en));
         chk({t, " mem_we"},  64'(mem_we),  64'(vt[i].e_we));
         chk_resp(t, vt[i].e_pv, vt[i].e_pe, vt[i].e_pd, vt[i].e_lv, vt[i].e_le, vt[i].e_ld);
      end
      chk("oob write left M[0] alone", mem[0], 64'h0);
      chk("M[0x21] written", mem[8'h21], 64'hBEEF);

      // Contention: both ports read for 9 cycles; L forced on the 5th.
      for (int i = 0; i < 9; i++) begin
         string t;
         @(negedge clk);
         t = $sformatf("cont%0d", i);
         p_req = 1; p_we = 0; p_addr = 64'h10;
         l_req = 1; l_we = 0; l_addr = 64'h20;
         #1;
         chk({t, " p_gnt"},   64'(p_gnt),   (i == 4) ? 64'h0 : 64'h1);
         chk({t, " l_gnt"},   64'(l_gnt),   (i == 4) ? 64'h1 : 64'h0);
         chk({t, " p_stall"}, 64'(p_stall), (i == 4) ? 64'h1 : 64'h0);
         if (i == 0)      chk_resp(t, 0,0,0, 0,0,0);
         else if (i == 5) chk_resp(t, 0,0,0, 1,0,64'hAAAA5555);
         else             chk_resp(t, 1,0,64'hDEAD, 0,0,0);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      chk_resp("cont tail", 1,0,64'hDEAD, 0,0,0);

      // Reset while a P read is in flight
      @(negedge clk);
      p_req = 1; p_we = 0; p_addr = 64'h10;
      #1;
      chk("rst-seq grant", 64'(p_gnt), 64'h1);
      @(posedge clk);
      #2;
      p_req = 0;
      rst_n = 0;
      #1;
      chk_resp("in reset", 0,0,0, 0,0,0);
      chk("in reset mem_en", 64'(mem_en), 64'h0);
      p_req = 1;
      #1;
      chk("in reset p_gnt masked", 64'(p_gnt), 64'h0);
      chk("in reset mem_en masked", 64'(mem_en), 64'h0);
      p_req = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
      chk_resp("post reset", 0,0,0, 0,0,0);
      @(negedge clk);
      p_req = 1; p_we = 0; p_addr = 64'h05;
      #1;
      chk("post reset grant", 64'(p_gnt), 64'h1);
      chk_resp("post reset idle2", 0,0,0, 0,0,0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk_resp("post reset read", 1,0,64'h1234, 0,0,0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
